// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: opcode and ALU operation encodings
// plus the control FSM state enum.
package stack_cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        StIf,
        StId,
        StPopA,
        StPopB,
        StExec,
        StPushRes,
        StMemRd,
        StPushMem,
        StMemWr,
        StJmpS,
        StJzPop,
        StJzChk
    } state_e;

endpackage

// File: rtl/stack_controller.sv
// Moore control FSM for the stack CPU: sequences fetch, decode, operand pops,
// ALU execution, memory transfers and jumps by driving datapath strobes.
module stack_controller
    import stack_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] inst,
    output logic       ld_IR,
    output logic       PCorIR,
    output logic       push,
    output logic       pop,
    output logic       MEMorALU,
    output logic       ldA,
    output logic       ldB,
    output logic       PCup,
    output logic       PCwrite,
    output logic       J,
    output logic       JZ,
    output logic       write_enable,
    output logic [1:0] ALUop
);

    state_e     state_q, state_d;
    logic [2:0] op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIf;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == StId) begin
                op_q <= inst;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_IR        = 1'b0;
        PCorIR       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        MEMorALU     = 1'b0;
        ldA          = 1'b0;
        ldB          = 1'b0;
        PCup         = 1'b0;
        PCwrite      = 1'b0;
        J            = 1'b0;
        JZ           = 1'b0;
        write_enable = 1'b0;
        ALUop        = ALU_ADD;

        unique case (state_q)
            StIf: begin
                ld_IR   = 1'b1;
                PCup    = 1'b1;
                state_d = StId;
            end
            StId: begin
                // Jumps leave PC alone here; they write it once the target is chosen.
                PCup    = 1'b1;
                PCwrite = (inst != OP_JMP) && (inst != OP_JZ);
                case (inst)
                    OP_PUSH: state_d = StMemRd;
                    OP_JMP:  state_d = StJmpS;
                    OP_JZ:   state_d = StJzPop;
                    default: state_d = StPopA;
                endcase
            end
            StPopA: begin
                ldA = 1'b1;
                pop = 1'b1;
                if (op_q == OP_POP) begin
                    state_d = StMemWr;
                end else if (op_q == OP_NOT) begin
                    state_d = StExec;
                end else begin
                    state_d = StPopB;
                end
            end
            StPopB: begin
                ldB     = 1'b1;
                pop     = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                ALUop   = op_q[1:0];
                state_d = StPushRes;
            end
            StPushRes: begin
                push     = 1'b1;
                MEMorALU = 1'b1;
                ALUop    = op_q[1:0];
                state_d  = StIf;
            end
            StMemRd: begin
                PCorIR  = 1'b1;
                state_d = StPushMem;
            end
            StPushMem: begin
                PCorIR  = 1'b1;
                push    = 1'b1;
                state_d = StIf;
            end
            StMemWr: begin
                PCorIR       = 1'b1;
                write_enable = 1'b1;
                state_d      = StIf;
            end
            StJmpS: begin
                J       = 1'b1;
                PCwrite = 1'b1;
                state_d = StIf;
            end
            StJzPop: begin
                ldA     = 1'b1;
                pop     = 1'b1;
                PCup    = 1'b1;
                state_d = StJzChk;
            end
            StJzChk: begin
                JZ      = 1'b1;
                PCwrite = 1'b1;
                PCup    = 1'b1;
                state_d = StIf;
            end
            default: state_d = StIf;
        endcase

        if (rst) begin
            ld_IR        = 1'b0;
            PCorIR       = 1'b0;
            push         = 1'b0;
            pop          = 1'b0;
            MEMorALU     = 1'b0;
            ldA          = 1'b0;
            ldB          = 1'b0;
            PCup         = 1'b0;
            PCwrite      = 1'b0;
            J            = 1'b0;
            JZ           = 1'b0;
            write_enable = 1'b0;
            ALUop        = ALU_ADD;
        end
    end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk input 1 (all state updates on posedge); rst input 1 (synchronous, active-high).
REQ-002 SHALL have input inst, 3 bits: opcode IR[7:5] from the datapath.
REQ-003 SHALL have 1-bit outputs: ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable (datapath control strobes, active-high).
REQ-004 SHALL have output ALUop, 2 bits: 00 add, 01 sub, 10 and, 11 not.

Function
REQ-005 SHALL decode the opcodes as 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
REQ-006 SHALL be a Moore FSM with exactly these states: IF, ID, POP_A, POP_B, EXEC, PUSH_RES, MEM_RD, PUSH_MEM, MEM_WR, JMP_S, JZ_POP, JZ_CHK.
REQ-007 SHALL drive every output to 0 in every state unless it is listed below.
REQ-008 In IF, SHALL drive ld_IR=1 and PCup=1 (PCorIR=0), and go to ID.
REQ-009 In ID, SHALL drive PCup=1; SHALL drive PCwrite=1 unless the opcode is JMP or JZ; SHALL capture inst into an internal opcode register.
REQ-010 From ID, SHALL go as follows: ALU ops and POP -> POP_A; PUSH -> MEM_RD; JMP -> JMP_S; JZ -> JZ_POP.
REQ-011 In POP_A, SHALL drive ldA=1 and pop=1; next state: ADD/SUB/AND -> POP_B, NOT -> EXEC, POP -> MEM_WR.
REQ-012 In POP_B, SHALL drive ldB=1 and pop=1, and go to EXEC.
REQ-013 In EXEC, SHALL drive ALUop = opcode[1:0] with PCup=0, and go to PUSH_RES.
REQ-014 In PUSH_RES, SHALL drive push=1 and MEMorALU=1 and hold ALUop from EXEC, and go to IF.
REQ-015 In MEM_RD, SHALL drive PCorIR=1, and go to PUSH_MEM.
REQ-016 In PUSH_MEM, SHALL drive PCorIR=1 and push=1 (MEMorALU=0), and go to IF.
REQ-017 In MEM_WR, SHALL drive PCorIR=1 and write_enable=1, and go to IF.
REQ-018 In JMP_S, SHALL drive J=1 and PCwrite=1, and go to IF.
REQ-019 In JZ_POP, SHALL drive ldA=1, pop=1 and PCup=1, and go to JZ_CHK.
REQ-020 In JZ_CHK, SHALL drive JZ=1, PCwrite=1 and PCup=1, and go to IF; the datapath selects the target when A==0, otherwise PC+1.
REQ-021 SHALL use these instruction latencies in cycles: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
REQ-022 SHALL assert push, pop, write_enable and PCwrite for at most one cycle per state visit, and SHALL never assert push and pop in the same cycle.
REQ-023 SHALL sample inst only in ID; changes on inst in any other state SHALL have no effect.

Reset
REQ-024 While rst=1 at a posedge, the FSM SHALL load IF and the opcode register SHALL load 000.
REQ-025 While rst=1, all outputs SHALL be forced to 0 combinationally.
REQ-026 A reset asserted mid-instruction SHALL abandon that instruction with no further push, pop or write_enable; after release, fetch SHALL restart at IF.

Structure
REQ-027 SHALL take the opcode constants, the ALUop constants and the state enum from a shared package, stack_cpu_pkg.
REQ-028 SHALL be a single module with no sub-modules: one registered state, one registered opcode, and combinational next-state/output logic.

Verification
REQ-029 The bench SHALL cover reset: rst=1 for 2 cycles -> all outputs 0; first cycle after release -> ld_IR=1, PCup=1, all other outputs 0.
REQ-030 The bench SHALL cover SUB: inst=001 at ID -> cycles 3-4 ldA/pop then ldB/pop; cycles 5-6 ALUop=01; cycle 6 push=1, MEMorALU=1; back to IF at cycle 7.
REQ-031 The bench SHALL cover PUSH: inst=100 -> PCorIR=1 in cycles 3-4; push=1 only in cycle 4 with MEMorALU=0; IF at cycle 5.
REQ-032 The bench SHALL cover POP: inst=101 -> cycle 3 ldA=1, pop=1; cycle 4 write_enable=1, PCorIR=1 (exactly one write_enable pulse).
REQ-033 The bench SHALL cover jumps: inst=111 -> PCwrite=0 in ID; cycle 4 JZ=1, PCwrite=1, PCup=1. inst=110 -> cycle 3 J=1, PCwrite=1; IF at cycle 4.
REQ-034 The bench SHALL cover reset in EXEC: rst=1 during EXEC of ADD -> next cycle all outputs 0 with no push; after release -> IF.
